axi4_lite_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream AXI4-Lite slave (e.g. axi4_lite_slave) between NUM_M upstream AXI4-Lite masters. It serialises transactions, one write or one read at a time. Each transaction runs from address handshake to response handshake before the next grant is issued. It sits between the master-side interconnect stubs and the register slave.

---
 rtl/axi4_lite_arb_pkg.sv | 21 ++
 rtl/axi4_lite_arbiter_rr_pick.sv | 27 ++
 rtl/axi4_lite_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_axi4_lite_arbiter.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_arb_pkg.sv
// Shared encodings for the AXI4-Lite round-robin arbiter: FSM states,
// response codes and transaction kinds.
package axi4_lite_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WRESP = 3'd2,
    ST_READ  = 3'd3,
    ST_RDATA = 3'd4
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic KIND_WRITE = 1'b0;
  localparam logic KIND_READ  = 1'b1;

endpackage

// File: rtl/axi4_lite_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around, wins.
module rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  int c;

  // Scan from the farthest candidate back to ptr so the nearest one wins.
  always_comb begin
    idx_o = '0;
    vld_o = |req_i;
    c     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(ptr_i) + k;
      if (c >= N) c = c - N;
      if (req_i[c]) idx_o = IDX_W'(c);
    end
  end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite slave between NUM_M masters;
// one transaction (address through response) is in flight at a time.
module axi4_lite_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [NUM_M*ADDR_W-1:0]    S_AWADDR,
  input  logic [NUM_M-1:0]           S_AWVALID,
  output logic [NUM_M-1:0]           S_AWREADY,
  input  logic [NUM_M*DATA_W-1:0]    S_WDATA,
  input  logic [NUM_M*DATA_W/8-1:0]  S_WSTRB,
  input  logic [NUM_M-1:0]           S_WVALID,
  output logic [NUM_M-1:0]           S_WREADY,
  output logic [NUM_M*2-1:0]         S_BRESP,
  output logic [NUM_M-1:0]           S_BVALID,
  input  logic [NUM_M-1:0]           S_BREADY,
  input  logic [NUM_M*ADDR_W-1:0]    S_ARADDR,
  input  logic [NUM_M-1:0]           S_ARVALID,
  output logic [NUM_M-1:0]           S_ARREADY,
  output logic [NUM_M*DATA_W-1:0]    S_RDATA,
  output logic [NUM_M*2-1:0]         S_RRESP,
  output logic [NUM_M-1:0]           S_RVALID,
  input  logic [NUM_M-1:0]           S_RREADY,
  output logic [ADDR_W-1:0]          M_AWADDR,
  output logic                       M_AWVALID,
  input  logic                       M_AWREADY,
  output logic [DATA_W-1:0]          M_WDATA,
  output logic [DATA_W/8-1:0]        M_WSTRB,
  output logic                       M_WVALID,
  input  logic                       M_WREADY,
  input  logic [1:0]                 M_BRESP,
  input  logic                       M_BVALID,
  output logic                       M_BREADY,
  output logic [ADDR_W-1:0]          M_ARADDR,
  output logic                       M_ARVALID,
  input  logic                       M_ARREADY,
  input  logic [DATA_W-1:0]          M_RDATA,
  input  logic [1:0]                 M_RRESP,
  input  logic                       M_RVALID,
  output logic                       M_RREADY
);

  localparam int IDX_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int STRB_W = DATA_W / 8;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   g_q, g_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               last_kind_q, last_kind_d;

  logic [NUM_M-1:0]   wreq, rreq, req;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               pick_w, pick_r;
  logic [IDX_W-1:0]   g_next;

  logic [ADDR_W-1:0]  g_awaddr, g_araddr;
  logic [DATA_W-1:0]  g_wdata;
  logic [STRB_W-1:0]  g_wstrb;
  logic               g_awvalid, g_wvalid, g_arvalid, g_bready, g_rready;
  logic               aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign wreq = S_AWVALID | S_WVALID;
  assign rreq = S_ARVALID;
  assign req  = wreq | rreq;

  rr_pick #(.N(NUM_M), .IDX_W(IDX_W)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign pick_w = wreq[pick_idx];
  assign pick_r = rreq[pick_idx];
  assign g_next = (g_q == IDX_W'(NUM_M - 1)) ? '0 : g_q + 1'b1;

  always_comb begin
    g_awaddr  = '0;
    g_araddr  = '0;
    g_wdata   = '0;
    g_wstrb   = '0;
    g_awvalid = 1'b0;
    g_wvalid  = 1'b0;
    g_arvalid = 1'b0;
    g_bready  = 1'b0;
    g_rready  = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (IDX_W'(i) == g_q) begin
        g_awaddr  = S_AWADDR[i*ADDR_W +: ADDR_W];
        g_araddr  = S_ARADDR[i*ADDR_W +: ADDR_W];
        g_wdata   = S_WDATA[i*DATA_W +: DATA_W];
        g_wstrb   = S_WSTRB[i*STRB_W +: STRB_W];
        g_awvalid = S_AWVALID[i];
        g_wvalid  = S_WVALID[i];
        g_arvalid = S_ARVALID[i];
        g_bready  = S_BREADY[i];
        g_rready  = S_RREADY[i];
      end
    end
  end

  // Forwarding: only the granted slice and only in the matching state.
  always_comb begin
    M_AWADDR  = '0;
    M_AWVALID = 1'b0;
    M_WDATA   = '0;
    M_WSTRB   = '0;
    M_WVALID  = 1'b0;
    M_BREADY  = 1'b0;
    M_ARADDR  = '0;
    M_ARVALID = 1'b0;
    M_RREADY  = 1'b0;
    S_AWREADY = '0;
    S_WREADY  = '0;
    S_BRESP   = '0;
    S_BVALID  = '0;
    S_ARREADY = '0;
    S_RDATA   = '0;
    S_RRESP   = '0;
    S_RVALID  = '0;
    case (state_q)
      ST_WRITE: begin
        M_AWVALID = g_awvalid & ~aw_done_q;
        M_AWADDR  = aw_done_q ? '0 : g_awaddr;
        M_WVALID  = g_wvalid & ~w_done_q;
        M_WDATA   = w_done_q ? '0 : g_wdata;
        M_WSTRB   = w_done_q ? '0 : g_wstrb;
      end
      ST_WRESP: M_BREADY = g_bready;
      ST_READ: begin
        M_ARVALID = g_arvalid;
        M_ARADDR  = g_araddr;
      end
      ST_RDATA: M_RREADY = g_rready;
      default: ;
    endcase
    for (int i = 0; i < NUM_M; i++) begin
      if (IDX_W'(i) == g_q) begin
        case (state_q)
          ST_WRITE: begin
            S_AWREADY[i] = M_AWREADY & ~aw_done_q;
            S_WREADY[i]  = M_WREADY & ~w_done_q;
          end
          ST_WRESP: begin
            S_BVALID[i]       = M_BVALID;
            S_BRESP[2*i +: 2] = M_BRESP;
          end
          ST_READ: S_ARREADY[i] = M_ARREADY;
          ST_RDATA: begin
            S_RVALID[i]                = M_RVALID;
            S_RDATA[i*DATA_W +: DATA_W] = M_RDATA;
            S_RRESP[2*i +: 2]          = M_RRESP;
          end
          default: ;
        endcase
      end
    end
  end

  assign aw_hs = M_AWVALID & M_AWREADY;
  assign w_hs  = M_WVALID & M_WREADY;
  assign b_hs  = M_BVALID & M_BREADY;
  assign ar_hs = M_ARVALID & M_ARREADY;
  assign r_hs  = M_RVALID & M_RREADY;

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    ptr_d       = ptr_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    last_kind_d = last_kind_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          g_d = pick_idx;
          // A master with both kinds pending alternates, starting with write.
          if (pick_w && (!pick_r || last_kind_q == KIND_READ)) state_d = ST_WRITE;
          else                                                  state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (b_hs) begin
          state_d     = ST_IDLE;
          ptr_d       = g_next;
          last_kind_d = KIND_WRITE;
        end
      end
      ST_READ: begin
        if (ar_hs) state_d = ST_RDATA;
      end
      ST_RDATA: begin
        if (r_hs) begin
          state_d     = ST_IDLE;
          ptr_d       = g_next;
          last_kind_d = KIND_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      ptr_q       <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      last_kind_q <= KIND_READ;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      ptr_q       <= ptr_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      last_kind_q <= last_kind_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter with two masters; the bench plays
// both the upstream masters and the downstream slave.
module tb_axi4_lite_arbiter;
  import axi4_lite_arb_pkg::*;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              ACLK = 1'b0;
  logic              ARESET;
  logic [NM*AW-1:0]  S_AWADDR;
  logic [NM-1:0]     S_AWVALID, S_AWREADY;
  logic [NM*DW-1:0]  S_WDATA;
  logic [NM*DW/8-1:0] S_WSTRB;
  logic [NM-1:0]     S_WVALID, S_WREADY;
  logic [NM*2-1:0]   S_BRESP;
  logic [NM-1:0]     S_BVALID, S_BREADY;
  logic [NM*AW-1:0]  S_ARADDR;
  logic [NM-1:0]     S_ARVALID, S_ARREADY;
  logic [NM*DW-1:0]  S_RDATA;
  logic [NM*2-1:0]   S_RRESP;
  logic [NM-1:0]     S_RVALID, S_RREADY;
  logic [AW-1:0]     M_AWADDR, M_ARADDR;
  logic              M_AWVALID, M_AWREADY;
  logic [DW-1:0]     M_WDATA;
  logic [DW/8-1:0]   M_WSTRB;
  logic              M_WVALID, M_WREADY;
  logic [1:0]        M_BRESP;
  logic              M_BVALID, M_BREADY;
  logic              M_ARVALID, M_ARREADY;
  logic [DW-1:0]     M_RDATA;
  logic [1:0]        M_RRESP;
  logic              M_RVALID, M_RREADY;

  int checks   = 0;
  int failures = 0;
  int aw_hs_cnt = 0;
  int w_hs_cnt  = 0;
  int aw0, w0;

  wire [14:0] vr = {S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID,
                    M_AWVALID, M_WVALID, M_BREADY, M_ARVALID, M_RREADY};

  axi4_lite_arbiter #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) begin
    if (M_AWVALID && M_AWREADY) aw_hs_cnt++;
    if (M_WVALID && M_WREADY) w_hs_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge ACLK);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    S_AWADDR = '0; S_AWVALID = '0; S_WDATA = '0; S_WSTRB = '0; S_WVALID = '0;
    S_BREADY = '0; S_ARADDR = '0; S_ARVALID = '0; S_RREADY = '0;
    M_AWREADY = 0; M_WREADY = 0; M_BRESP = '0; M_BVALID = 0;
    M_ARREADY = 0; M_RDATA = '0; M_RRESP = '0; M_RVALID = 0;
  endtask

  task automatic do_reset;
    clear_inputs();
    ARESET = 1'b1;
    tick();
    tick();
    ARESET = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    settle();
    chk("rst_vr", 64'(vr), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("rst_maddr", {M_AWADDR, M_ARADDR}, 64'd0);

    // Single write from M0
    S_AWADDR = 64'h0; S_AWVALID = 2'b01;
    S_WDATA = {32'h0, 32'hCAFEBABE}; S_WSTRB = 8'h0F; S_WVALID = 2'b01;
    settle();
    chk("w1_arb_cycle_vr", 64'(vr), 64'd0);
    tick(); settle();
    chk("w1_awvalid", 64'(M_AWVALID), 64'd1);
    chk("w1_awaddr", 64'(M_AWADDR), 64'h0);
    chk("w1_wvalid", 64'(M_WVALID), 64'd1);
    chk("w1_wdata", 64'(M_WDATA), 64'hCAFEBABE);
    chk("w1_wstrb", 64'(M_WSTRB), 64'hF);
    chk("w1_rdy_before", 64'({S_AWREADY, S_WREADY}), 64'd0);
    M_AWREADY = 1; M_WREADY = 1; settle();
    chk("w1_rdy", 64'({S_AWREADY, S_WREADY}), 64'b0101);
    tick();
    S_AWVALID = '0; S_WVALID = '0; M_AWREADY = 0; M_WREADY = 0;
    M_BVALID = 1; M_BRESP = RESP_OKAY; S_BREADY = 2'b01; settle();
    chk("w1_bvalid", 64'(S_BVALID), 64'b01);
    chk("w1_bresp", 64'(S_BRESP), 64'd0);
    chk("w1_bready", 64'(M_BREADY), 64'd1);
    chk("w1_m1_rdy", 64'({S_AWREADY[1], S_WREADY[1], S_ARREADY[1]}), 64'd0);
    tick();
    M_BVALID = 0; S_BREADY = '0; settle();
    chk("w1_idle_vr", 64'(vr), 64'd0);

    // Simultaneous writes, then a second contended pair
    do_reset();
    S_AWADDR = {32'h14, 32'h10}; S_WDATA = {32'h22222222, 32'h11111111};
    S_WSTRB = 8'hFF; S_AWVALID = 2'b11; S_WVALID = 2'b11;
    tick(); settle();
    chk("p1_addr", 64'(M_AWADDR), 64'h10);
    chk("p1_data", 64'(M_WDATA), 64'h11111111);
    M_AWREADY = 1; M_WREADY = 1; settle();
    chk("p1_rdy", 64'({S_AWREADY, S_WREADY}), 64'b0101);
    tick();
    S_AWVALID = 2'b10; S_WVALID = 2'b10; M_AWREADY = 0; M_WREADY = 0;
    M_BVALID = 1; S_BREADY = 2'b11; settle();
    chk("p1_bvalid", 64'(S_BVALID), 64'b01);
    S_AWADDR[31:0] = 32'h18; S_WDATA[31:0] = 32'h33333333;
    S_AWVALID = 2'b11; S_WVALID = 2'b11;
    tick();
    M_BVALID = 0; settle();
    chk("p1_idle_vr", 64'(vr), 64'd0);
    tick(); settle();
    chk("p2_addr", 64'(M_AWADDR), 64'h14);
    chk("p2_data", 64'(M_WDATA), 64'h22222222);
    M_AWREADY = 1; M_WREADY = 1; settle();
    chk("p2_rdy", 64'({S_AWREADY, S_WREADY}), 64'b1010);
    tick();
    S_AWVALID = 2'b01; S_WVALID = 2'b01; M_AWREADY = 0; M_WREADY = 0;
    M_BVALID = 1; M_BRESP = RESP_SLVERR; settle();
    chk("p2_b_slverr", 64'({S_BVALID, S_BRESP}), 64'b10_1000);
    tick();
    M_BVALID = 0; M_BRESP = RESP_OKAY;
    tick(); settle();
    chk("p3_wrap_addr", 64'(M_AWADDR), 64'h18);

    // Reads from M1 then M0
    do_reset();
    S_ARADDR = {32'h4, 32'h0}; S_ARVALID = 2'b10;
    tick(); settle();
    chk("r1_arvalid", 64'(M_ARVALID), 64'd1);
    chk("r1_araddr", 64'(M_ARADDR), 64'h4);
    chk("r1_arrdy_before", 64'(S_ARREADY), 64'd0);
    M_ARREADY = 1; settle();
    chk("r1_arrdy", 64'(S_ARREADY), 64'b10);
    tick();
    S_ARVALID = '0; M_ARREADY = 0;
    M_RVALID = 1; M_RDATA = 32'hDEADBEEF; M_RRESP = RESP_OKAY; S_RREADY = 2'b10; settle();
    chk("r1_rdata", S_RDATA, 64'hDEADBEEF_00000000);
    chk("r1_rvalid", 64'(S_RVALID), 64'b10);
    chk("r1_rresp_rready", 64'({S_RRESP, M_RREADY}), 64'b0000_1);
    tick();
    M_RVALID = 0; S_RREADY = '0; S_ARVALID = 2'b01;
    tick(); settle();
    chk("r2_ar", 64'({M_ARVALID, M_ARADDR}), {31'd0, 1'b1, 32'h0});
    M_ARREADY = 1;
    tick();
    S_ARVALID = '0; M_ARREADY = 0;
    M_RVALID = 1; M_RDATA = 32'hCAFEBABE; M_RRESP = RESP_DECERR; S_RREADY = 2'b01; settle();
    chk("r2_rdata", S_RDATA, 64'h00000000_CAFEBABE);
    chk("r2_rresp", 64'(S_RRESP), 64'b0011);
    tick();
    M_RVALID = 0; S_RREADY = '0;

    // M0 with both write and read pending: write first, then read
    do_reset();
    S_AWADDR[31:0] = 32'h20; S_WDATA[31:0] = 32'h44; S_WSTRB = 8'h0F;
    S_ARADDR[31:0] = 32'h24;
    S_AWVALID = 2'b01; S_WVALID = 2'b01; S_ARVALID = 2'b01;
    tick(); settle();
    chk("k1_write_first", 64'({M_AWVALID, M_ARVALID}), 64'b10);
    M_AWREADY = 1; M_WREADY = 1;
    tick();
    S_AWVALID = '0; S_WVALID = '0; M_AWREADY = 0; M_WREADY = 0;
    M_BVALID = 1; S_BREADY = 2'b01; settle();
    chk("k1_bvalid", 64'(S_BVALID), 64'b01);
    S_AWVALID = 2'b01; S_WVALID = 2'b01;
    tick();
    M_BVALID = 0; S_BREADY = '0;
    tick(); settle();
    chk("k2_read_next", 64'({M_AWVALID, M_ARVALID}), 64'b01);
    chk("k2_araddr", 64'(M_ARADDR), 64'h24);

    // AW three cycles ahead of W, downstream readies in different cycles
    do_reset();
    aw0 = aw_hs_cnt; w0 = w_hs_cnt;
    S_AWADDR[31:0] = 32'h8; S_AWVALID = 2'b01;
    S_WDATA[31:0] = 32'h55; S_WSTRB = 8'h0F;
    tick(); settle();
    chk("s_aw_only", 64'({M_AWVALID, M_WVALID}), 64'b10);
    M_AWREADY = 1; settle();
    chk("s_awrdy", 64'(S_AWREADY), 64'b01);
    tick(); settle();
    chk("s_aw_gated", 64'({M_AWVALID, S_AWREADY}), 64'd0);
    tick();
    M_AWREADY = 0; S_WVALID = 2'b01; settle();
    chk("s_w_on", 64'({M_WVALID, S_WREADY}), 64'b1_00);
    chk("s_wdata", 64'(M_WDATA), 64'h55);
    tick();
    M_WREADY = 1; settle();
    chk("s_wrdy", 64'(S_WREADY), 64'b01);
    chk("s_state_write", 64'(dut.state_q), 64'(ST_WRITE));
    tick();
    S_AWVALID = '0; S_WVALID = '0; M_WREADY = 0; settle();
    chk("s_state_wresp", 64'(dut.state_q), 64'(ST_WRESP));
    chk("s_aw_count", 64'(aw_hs_cnt - aw0), 64'd1);
    chk("s_w_count", 64'(w_hs_cnt - w0), 64'd1);

    // BREADY held low while M1 requests a read
    M_BVALID = 1; S_BREADY = '0;
    S_ARADDR[63:32] = 32'hC; S_ARVALID = 2'b10;
    for (int i = 0; i < 5; i++) begin
      tick(); settle();
      chk("bp_hold", 64'({S_BVALID, M_ARVALID, S_ARREADY}), 64'b01_0_00);
    end
    S_BREADY = 2'b01; settle();
    chk("bp_bready", 64'(M_BREADY), 64'd1);
    tick();
    M_BVALID = 0; S_BREADY = '0;
    tick(); settle();
    chk("bp_grant_m1", 64'({M_ARVALID, M_ARADDR}), {31'd0, 1'b1, 32'hC});
    M_ARREADY = 1;
    tick();
    S_ARVALID = '0; M_ARREADY = 0; M_RVALID = 1; M_RDATA = 32'h12345678; S_RREADY = '0; settle();
    chk("rd_rvalid", 64'(S_RVALID), 64'b10);

    // Reset during RDATA
    ARESET = 1'b1;
    tick(); settle();
    chk("mid_rst_vr", 64'(vr), 64'd0);
    chk("mid_rst_state", 64'(dut.state_q), 64'(ST_IDLE));
    chk("mid_rst_rdata", S_RDATA, 64'd0);
    ARESET = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
